// File: rtl/ota_jtag_pkg.sv
// Shared types and constants for the JTAGG ER1 OTA responder.
// Optional unlock gate: OTA_JTAG_UNLOCK_EN.
package ota_jtag_pkg;

  localparam int FRAME_W = 40;
  localparam int CNT_W   = 6;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_WRITE_ADDR = 8'h70;
  localparam logic [7:0] OP_REBOOT     = 8'h79;
  localparam logic [7:0] OP_UNLOCK     = 8'h5A;

  localparam logic [31:0] UNLOCK_KEY = 32'hB007_CAFE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  op;
  } frame_t;

endpackage

// File: rtl/jtag_edge_sync.sv
// Multi-bit synchronizer with rise/fall detect on the settled samples.
// One extra history flop feeds the edge detectors.
module jtag_edge_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] stg;
  logic [W-1:0]             prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg  <= '0;
      prev <= '0;
    end else begin
      stg  <= {stg[STAGES-2:0], d};
      prev <= stg[STAGES-1];
    end
  end

  assign q    = stg[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/ota_jtag_responder.sv
// Fabric-side ER1 responder: shifts 40-bit frames, decodes on Update-DR.
// Define OTA_JTAG_UNLOCK_EN to gate REBOOT behind an UNLOCK frame.
module ota_jtag_responder
  import ota_jtag_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [7:0]  CAPTURE_TAG  = 8'hA5,
  parameter logic [31:0] DEFAULT_ADDR = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jtck,
  input  logic        jtdi,
  input  logic        jshift,
  input  logic        jupdate,
  input  logic        jce1,
  input  logic        jrstn,
  output logic        jtdo1,
  input  logic [31:0] status_in,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [31:0] cmd_data,
  output logic        reboot_req,
  output logic [31:0] reboot_addr,
  output logic        frame_err
);

  logic [5:0] j_q, j_rise, j_fall;

  jtag_edge_sync #(.W(6), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({jtck, jtdi, jshift, jupdate, jce1, jrstn}),
    .q    (j_q),
    .rise (j_rise),
    .fall (j_fall)
  );

  logic tck_rise, tck_fall, upd_rise;
  logic tdi_s, shift_s, ce1_s, rstn_s;
  logic unused_edges;

  assign tck_rise = j_rise[5];
  assign tck_fall = j_fall[5];
  assign upd_rise = j_rise[2];
  assign tdi_s    = j_q[4];
  assign shift_s  = j_q[3];
  assign ce1_s    = j_q[1];
  assign rstn_s   = j_q[0];
  assign unused_edges = ^{j_q[5], j_q[2], j_rise[4:3],
                          j_rise[1:0], j_fall[4:0]};

  state_t             state;
  logic [FRAME_W-1:0] sr;
  logic [CNT_W-1:0]   cnt;
  frame_t             fr;
  logic               capture, shift_en;
  logic               is_wr, is_rb;

  assign fr       = frame_t'(sr);
  assign capture  = tck_rise & ce1_s & ~shift_s;
  assign shift_en = tck_rise & ce1_s & shift_s;
  assign is_wr    = (fr.op == OP_WRITE_ADDR);
  assign is_rb    = (fr.op == OP_REBOOT);

`ifdef OTA_JTAG_UNLOCK_EN
  logic armed;
  logic is_unlock;
  assign is_unlock = (fr.op == OP_UNLOCK) && (fr.data == UNLOCK_KEY);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sr          <= '0;
      cnt         <= '0;
      jtdo1       <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_data    <= '0;
      reboot_req  <= 1'b0;
      reboot_addr <= DEFAULT_ADDR;
      frame_err   <= 1'b0;
`ifdef OTA_JTAG_UNLOCK_EN
      armed       <= 1'b0;
`endif
    end else begin
      cmd_valid  <= 1'b0;
      reboot_req <= 1'b0;
      frame_err  <= 1'b0;
      // TDO moves on the falling edge so the host samples it stable
      if (tck_fall) jtdo1 <= sr[0];
      if (!rstn_s) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (capture) begin
              sr    <= {status_in, CAPTURE_TAG};
              cnt   <= '0;
              state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (capture) begin
              sr  <= {status_in, CAPTURE_TAG};
              cnt <= '0;
            end else if (shift_en) begin
              sr <= {tdi_s, sr[FRAME_W-1:1]};
              if (cnt != CNT_W'(FRAME_W + 1)) cnt <= cnt + 1'b1;
            end else if (upd_rise) begin
              state <= ST_DECODE;
            end
          end
          ST_DECODE: begin
            state <= ST_IDLE;
            if (cnt == CNT_W'(FRAME_W)) begin
              cmd_valid <= 1'b1;
              cmd_op    <= fr.op;
              cmd_data  <= fr.data;
`ifdef OTA_JTAG_UNLOCK_EN
              armed     <= is_unlock;
`endif
              unique case (1'b1)
                is_wr: reboot_addr <= fr.data;
                is_rb: begin
`ifdef OTA_JTAG_UNLOCK_EN
                  reboot_req <= armed;
                  frame_err  <= ~armed;
`else
                  reboot_req <= 1'b1;
`endif
                end
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ota_jtag_responder.md
Name: ota_jtag_responder

Overview:
Fabric-side responder for the JTAGG ER1 user data register. An external host (RP2040) drives the ECP5 JTAG port and shifts 40-bit command frames in; this block receives them. It samples the JTAGG fabric outputs in the system clock domain, shifts frames LSB-first, and decodes them on Update-DR. Decoded frames become a command strobe and a reboot request/address pair for the OTA reboot path. Captured status is returned on TDO.

Parameters:
FRAME_W, 40, frame width: bits [7:0] opcode, [39:8] data
SYNC_STAGES, 2, synchronizer depth for the JTAGG inputs
CAPTURE_TAG, 8'hA5, constant loaded into bits [7:0] at Capture-DR
DEFAULT_ADDR, 32'h0010_0000, reset value of reboot_addr

Ports:
clk  in  1  system clock; must be at least 4x the JTCK frequency
rst_n  in  1  asynchronous active-low reset
jtck  in  1  JTAGG JTCK (sampled as data, never used as a clock)
jtdi  in  1  JTAGG JTDI
jshift  in  1  JTAGG JSHIFT
jupdate  in  1  JTAGG JUPDATE
jce1  in  1  JTAGG JCE1 (ER1 selected)
jrstn  in  1  JTAGG JRSTN (TAP reset, active low)
jtdo1  out  1  to JTAGG JTDO1
status_in  in  32  status word returned at capture
cmd_valid  out  1  one-cycle pulse for each well-formed frame
cmd_op  out  8  opcode of last frame, held between pulses
cmd_data  out  32  data of last frame, held between pulses
reboot_req  out  1  one-cycle pulse requesting reboot
reboot_addr  out  32  stored jump address
frame_err  out  1  one-cycle pulse for a malformed or rejected frame

Behaviour:
- Reset values: jtdo1=0, cmd_valid=0, cmd_op=0, cmd_data=0, reboot_req=0, reboot_addr=DEFAULT_ADDR, frame_err=0, shift register=0, bit counter=0, FSM=IDLE.
- All J* inputs pass through a SYNC_STAGES flip-flop synchronizer. jtck rise and fall are detected from the last two synchronized samples. jupdate rise is detected the same way.
- FSM states:
  - IDLE: on jtck rise with jce1=1 and jshift=0, load the shift register with {status_in, CAPTURE_TAG}, clear the bit counter, and go to SHIFT.
  - SHIFT: on jtck rise with jce1=1 and jshift=1, shift jtdi in at the MSB and shift right; the counter increments and saturates at FRAME_W+1. On a jupdate rise, go to DECODE.
  - DECODE: lasts one cycle, then returns to IDLE.
- jtdo1 equals shift register bit 0. It updates only on jtck fall, so TDO is stable at the host's rising-edge sample.
- DECODE with counter == FRAME_W:
  - cmd_valid=1; cmd_op and cmd_data take the frame fields.
  - Opcode 8'h70 (WRITE_ADDR): reboot_addr <= data.
  - Opcode 8'h79 (REBOOT): reboot_req=1. reboot_addr is unchanged and already valid in the same cycle.
  - Opcode 8'h00 and any other opcode: cmd_valid only, no internal action.
- DECODE with counter != FRAME_W (short, or over-long and saturated): frame_err=1, cmd_valid=0, no state change.
- A jupdate rise seen in IDLE (no capture happened) is ignored.
- Synchronized jrstn=0 from any state: FSM goes to IDLE and the counter clears. Registered outputs, including reboot_addr, are kept. No pulse is emitted for the aborted frame.
- rst_n assertion mid-frame: every register takes its reset value immediately.
- Capture and update in the same clk cycle cannot occur legally. If it happens, capture wins.
- Total latency: Update-DR edge at the pins to the cmd_valid pulse is SYNC_STAGES+2 clk cycles.

Optional Feature:
Macro OTA_JTAG_UNLOCK_EN.
- Defined:
  - Opcode 8'h5A with data 32'hB007_CAFE arms an unlock flag; it also produces cmd_valid.
  - REBOOT is honoured only when the immediately preceding well-formed frame armed the flag. Any other well-formed frame clears it.
  - REBOOT without the flag: cmd_valid=1, frame_err=1, reboot_req=0.
- Undefined: no flag exists, and REBOOT is always honoured.

Decomposition:
- Package ota_jtag_pkg holds:
  - opcode constants OP_NOP, OP_WRITE_ADDR, OP_REBOOT, OP_UNLOCK
  - UNLOCK_KEY
  - FRAME_W
  - the FSM state enum
  - a packed frame struct {data[31:0], op[7:0]}
- Sub-module jtag_edge_sync holds the synchronizer plus rise/fall detect. It is instantiated once, vectorised over the input bits.

Test Plan:
1. Capture with status_in=32'hDEAD_BEEF, then shift 40 bits out: host reads 40'hDEAD_BEEF_A5 LSB-first on jtdo1.
2. Frame {32'h0020_0000, 8'h70} then update: cmd_valid pulses once, cmd_op=8'h70, reboot_addr=32'h0020_0000, reboot_req stays 0.
3. Frame {32'h0, 8'h79}: reboot_req pulses exactly one cycle with reboot_addr=32'h0010_0000 (reset default); then send WRITE_ADDR and REBOOT back to back and check the new address.
4. Shift 39 bits then update, and separately shift 41 bits then update: frame_err pulses each time, cmd_valid=0, reboot_addr unchanged.
5. jrstn low after 20 bits, then a full valid frame: only the second frame produces cmd_valid. Assert rst_n mid-shift: all outputs return to their reset values.
6. With OTA_JTAG_UNLOCK_EN:
   - REBOOT alone: frame_err=1, reboot_req=0.
   - UNLOCK(32'hB007_CAFE) then REBOOT: reboot_req=1.
   - UNLOCK, NOP, REBOOT: frame_err=1.
